// File: rtl/inst_pair_queue_if.sv
// Instruction-pair types and the decode->queue->dispatch handshake bundle
// used by inst_pair_queue.
package inst_pair_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op;
  } instruction_info_reg_t;

  // Slot 0 is the older instruction of the pair.
  typedef instruction_info_reg_t [1:0] pair_t;
endpackage

interface inst_pair_queue_if #(
  parameter int DEPTH_BITS = 3
);
  import inst_pair_queue_pkg::*;

  logic                in_valid;
  pair_t               in_inst;
  logic                full;
  logic                out_valid;
  pair_t               out_inst;
  logic                out_ready;
  logic                flush;
  logic [DEPTH_BITS:0] count;
  logic                overflow;

  modport master (
    output in_valid, in_inst, out_ready, flush,
    input  full, out_valid, out_inst, count, overflow
  );

  modport slave (
    input  in_valid, in_inst, out_ready, flush,
    output full, out_valid, out_inst, count, overflow
  );
endinterface

// File: rtl/inst_pair_queue.sv
// Circular FIFO of decoded instruction pairs between decode and rename/dispatch.
// Optional same-cycle bypass on an empty queue: define INST_QUEUE_BYPASS_EN.
module inst_pair_queue
  import inst_pair_queue_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int DEPTH_BITS  = 3,
  parameter int SUPERSCALAR = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  inst_pair_queue_if.slave     q
);

  typedef instruction_info_reg_t [SUPERSCALAR-1:0] entry_t;

  entry_t                mem [DEPTH];
  logic [DEPTH_BITS:0]   head, tail;
  logic                  empty, full, byp, byp_take, push, pop, ovf;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (head == tail);
  assign full  = (head[DEPTH_BITS-1:0] == tail[DEPTH_BITS-1:0]) &&
                 (head[DEPTH_BITS] != tail[DEPTH_BITS]);

`ifdef INST_QUEUE_BYPASS_EN
  assign byp = empty && q.in_valid && !q.flush;
`else
  assign byp = 1'b0;
`endif

  assign byp_take = byp && q.out_ready;
  assign pop      = !empty && q.out_ready;
  assign push     = q.in_valid && !full && !byp_take;

  assign q.full      = full;
  assign q.count     = tail - head;
  assign q.out_valid = !empty || byp;
  assign q.overflow  = ovf;

  always_comb begin
    q.out_inst = '0;
    if (!empty)   q.out_inst = mem[head[DEPTH_BITS-1:0]];
    else if (byp) q.out_inst = q.in_inst;
  end

  // Flush resets pointers only; stale storage is unreachable afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      ovf  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (q.flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) begin
        mem[tail[DEPTH_BITS-1:0]] <= q.in_inst;
        tail <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      if (q.in_valid && full) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_pair_queue.sv
// Self-checking bench for inst_pair_queue: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_inst_pair_queue;
  import inst_pair_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int DB    = 3;
`ifdef INST_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_pair_queue_if #(.DEPTH_BITS(DB)) bus ();

  inst_pair_queue #(.DEPTH(DEPTH), .DEPTH_BITS(DB), .SUPERSCALAR(2)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  int n_pass = 0;
  int n_total = 0;

  pair_t mq[$];
  bit    m_ovf = 1'b0;

  typedef struct {
    bit rst;
    bit iv;
    int id;
    bit ordy;
    bit fl;
    bit mchk;
    bit tchk;
    bit ev;
    int ecnt;
    bit eovf;
    int eid;
  } vec_t;

  function automatic pair_t mk(int id);
    pair_t p;
    p[0].pc = id * 8;
    p[0].op = id ^ 32'hA5A5_0000;
    p[1].pc = id * 8 + 4;
    p[1].op = ~id;
    return p;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step(vec_t v);
    pair_t pin = mk(v.id);
    bit    ev;
    pair_t einst;
    bit    was_full, byp_take;
    bus.in_valid  = v.iv;
    bus.in_inst   = pin;
    bus.out_ready = v.ordy;
    bus.flush     = v.fl;
    rst           = v.rst;
    @(negedge clk);
    if (v.mchk) begin
      ev    = (mq.size() > 0) || (BYP && v.iv && !v.fl);
      einst = (mq.size() > 0) ? mq[0] : (ev ? pin : pair_t'('0));
      chk("m_out_valid", 128'(bus.out_valid), 128'(ev));
      chk("m_out_inst",  128'(bus.out_inst),  128'(einst));
      chk("m_count",     128'(bus.count),     128'(mq.size()));
      chk("m_full",      128'(bus.full),      128'(mq.size() == DEPTH));
      chk("m_overflow",  128'(bus.overflow),  128'(m_ovf));
    end
    if (v.tchk) begin
      chk("t_out_valid", 128'(bus.out_valid), 128'(v.ev));
      chk("t_out_inst",  128'(bus.out_inst),  v.ev ? 128'(mk(v.eid)) : 128'(0));
      chk("t_count",     128'(bus.count),     128'(v.ecnt));
      chk("t_overflow",  128'(bus.overflow),  128'(v.eovf));
    end
    @(posedge clk);
    if (!v.rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (v.fl) begin
      mq.delete();
    end else begin
      was_full = (mq.size() == DEPTH);
      byp_take = BYP && mq.size() == 0 && v.iv && v.ordy;
      if (v.iv && was_full) m_ovf = 1'b1;
      if (mq.size() > 0 && v.ordy) void'(mq.pop_front());
      if (v.iv && !was_full && !byp_take) mq.push_back(pin);
    end
    #1;
  endtask

  task automatic cyc(bit r, bit iv, int id, bit ordy, bit fl);
    vec_t v = '{rst: r, iv: iv, id: id, ordy: ordy, fl: fl, mchk: 1'b1,
                tchk: 1'b0, ev: 1'b0, ecnt: 0, eovf: 1'b0, eid: 0};
    step(v);
  endtask

  // Directed table: expectations are what is seen during the row's cycle.
  vec_t tbl[21];

  initial begin
    //          rst iv id ordy fl mchk tchk ev cnt ovf eid
    tbl[0]  = '{0, 1, 99, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 99, 1, 0, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 1,  0, 0, 1, 1, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 2,  0, 0, 1, 1, 1, 1, 0, 1};
    tbl[4]  = '{1, 1, 3,  0, 0, 1, 1, 1, 2, 0, 1};
    tbl[5]  = '{1, 0, 0,  0, 0, 1, 1, 1, 3, 0, 1};
    tbl[6]  = '{1, 0, 0,  1, 0, 1, 1, 1, 3, 0, 1};
    tbl[7]  = '{1, 0, 0,  1, 0, 1, 1, 1, 2, 0, 2};
    tbl[8]  = '{1, 0, 0,  1, 0, 1, 1, 1, 1, 0, 3};
    tbl[9]  = '{1, 0, 0,  0, 0, 1, 1, 0, 0, 0, 0};
    tbl[10] = '{1, 1, 10, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[11] = '{1, 1, 11, 0, 0, 1, 1, 1, 1, 0, 10};
    tbl[12] = '{1, 1, 12, 0, 0, 1, 1, 1, 2, 0, 10};
    tbl[13] = '{1, 1, 13, 0, 0, 1, 1, 1, 3, 0, 10};
    tbl[14] = '{1, 1, 14, 0, 0, 1, 1, 1, 4, 0, 10};
    tbl[15] = '{1, 1, 15, 1, 1, 1, 1, 1, 5, 0, 10};
    tbl[16] = '{1, 0, 0,  0, 0, 1, 1, 0, 0, 0, 0};
    tbl[17] = '{1, 1, 16, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[18] = '{1, 0, 0,  0, 0, 1, 1, 1, 1, 0, 16};
    tbl[19] = '{1, 0, 0,  1, 0, 1, 1, 1, 1, 0, 16};
    tbl[20] = '{1, 0, 0,  0, 0, 1, 1, 0, 0, 0, 0};

    for (int i = 0; i < 21; i++) begin
      // Bypass changes same-cycle visibility; the table assumes the default build.
      if (BYP) tbl[i].tchk = 1'b0;
      step(tbl[i]);
    end

    // Fill to full, then a push while full that also pops.
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 20 + i, 0, 0);
    chk("full_at_8", 128'(bus.full), 128'(1));
    chk("count_at_8", 128'(bus.count), 128'(8));
    cyc(1, 1, 28, 1, 0);
    chk("ovf_after_drop", 128'(bus.overflow), 128'(1));
    chk("count_after_drop", 128'(bus.count), 128'(7));
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1, 0);
    chk("drained_valid", 128'(bus.out_valid), 128'(0));

    // Advance pointers, then steady push/pop at count 2 across the wrap.
    for (int i = 0; i < 6; i++) cyc(1, 1, 40 + i, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 50, 0, 0);
    cyc(1, 1, 51, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 1, 52 + i, 1, 0);
    chk("wrap_count", 128'(bus.count), 128'(2));

    // Mid-operation reset with overflow set and six entries held.
    for (int i = 0; i < 4; i++) cyc(1, 1, 80 + i, 0, 0);
    chk("pre_rst_count", 128'(bus.count), 128'(6));
    cyc(0, 1, 90, 1, 1);
    chk("rst_count", 128'(bus.count), 128'(0));
    chk("rst_ovf", 128'(bus.overflow), 128'(0));
    chk("rst_out_inst", 128'(bus.out_inst), 128'(0));
    cyc(1, 1, 91, 0, 0);
    cyc(1, 1, 92, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 63) != 0), $urandom_range(0, 1) == 1,
          200 + i, $urandom_range(0, 2) == 0, $urandom_range(0, 31) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
